// File: rtl/mux8_frame_serializer.sv
// Byte-to-serial framer that drives an external 8:1 mux and registers its output bit by bit.
// Optional even-parity trailer bit is enabled with the MUX8_SER_PARITY_EN macro.
module mux8_frame_serializer #(
    parameter int MSB_FIRST = 0,
    parameter int IDLE_GAP  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] mux_a,
    output logic [2:0] mux_sel,
    input  logic       mux_y,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_last,
    output logic       busy
);

    // Handshake: a word moves when in_valid && in_ready are both high at a rising edge.
    localparam logic [2:0] START    = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
    localparam logic [3:0] GAP_LAST = 4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

`ifdef MUX8_SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

    state_t     state, state_nx;
    logic [7:0] a_nx;
    logic [2:0] sel_nx;
    logic [2:0] bit_cnt, cnt_nx;
    logic [3:0] gap_cnt, gap_nx;
    logic       out_nx, valid_nx, last_nx;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mux_a     <= 8'd0;
            mux_sel   <= START;
            bit_cnt   <= 3'd0;
            gap_cnt   <= 4'd0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            state     <= state_nx;
            mux_a     <= a_nx;
            mux_sel   <= sel_nx;
            bit_cnt   <= cnt_nx;
            gap_cnt   <= gap_nx;
            ser_out   <= out_nx;
            ser_valid <= valid_nx;
            ser_last  <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = mux_a;
        sel_nx   = mux_sel;
        cnt_nx   = bit_cnt;
        gap_nx   = gap_cnt;
        out_nx   = 1'b0;
        valid_nx = 1'b0;
        last_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_nx     = in_data;
                    sel_nx   = START;
                    cnt_nx   = 3'd0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                // mux_y reflects the current select, so the bit is captured one cycle behind mux_sel.
                out_nx   = mux_y;
                valid_nx = 1'b1;
                cnt_nx   = bit_cnt + 3'd1;
                sel_nx   = (MSB_FIRST != 0) ? mux_sel - 3'd1 : mux_sel + 3'd1;
                if (bit_cnt == 3'd7) begin
                    sel_nx = START;
                    cnt_nx = 3'd0;
                    gap_nx = 4'd0;
`ifdef MUX8_SER_PARITY_EN
                    state_nx = PAR;
`else
                    last_nx  = 1'b1;
                    state_nx = (IDLE_GAP > 0) ? GAP : IDLE;
`endif
                end
            end
`ifdef MUX8_SER_PARITY_EN
            PAR: begin
                out_nx   = ^mux_a;
                valid_nx = 1'b1;
                last_nx  = 1'b1;
                gap_nx   = 4'd0;
                state_nx = (IDLE_GAP > 0) ? GAP : IDLE;
            end
`endif
            GAP: begin
                gap_nx = gap_cnt + 4'd1;
                if (gap_cnt == GAP_LAST) begin
                    gap_nx   = 4'd0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/mux8_frame_serializer.md
Name: mux8_frame_serializer

Overview:
- Upstream controller for the 8:1 mux datapath: accepts an 8-bit word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the 3-bit select through all eight positions, one per clock.
- Registers the returned mux output into a framed serial bit stream with valid and last flags.
- Sits between a byte-wide producer and the serial consumer, wrapped around the existing 8:1 mux.

Parameters:
- MSB_FIRST, 0: 0 = select sequence 0→7 (LSB first); 1 = select sequence 7→0.
- IDLE_GAP, 0: number of extra GAP cycles inserted after each word before returning to IDLE. Legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word on in_data
- in_data  input  8  word to serialize
- in_ready  output  1  block can accept a word
- mux_a  output  8  held word, drives the mux data inputs
- mux_sel  output  3  drives the mux select
- mux_y  input  1  combinational mux output, returned the same cycle
- ser_out  output  1  serial data bit
- ser_valid  output  1  ser_out carries a valid bit this cycle
- ser_last  output  1  final bit of the current frame
- busy  output  1  high whenever state is not IDLE

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).

Reset values:
- state = IDLE.
- mux_a = 0.
- mux_sel = start index: 0 when MSB_FIRST=0, 7 when MSB_FIRST=1.
- ser_out, ser_valid, ser_last, busy = 0.
- bit counter = 0, gap counter = 0.
- in_ready = 1, decoded combinationally from state==IDLE.

States: IDLE, SHIFT, GAP (plus PAR when PARITY_EN is defined).

IDLE:
- in_ready = 1.
- When in_valid && in_ready is sampled at an edge:
  - mux_a <= in_data;
  - mux_sel <= start index;
  - counter <= 0;
  - state goes to SHIFT.

SHIFT:
- in_ready = 0; in_valid is ignored and in_data changes do not affect mux_a.
- Each cycle: ser_out <= mux_y, ser_valid <= 1, mux_sel steps by ±1 (wraps modulo 8 only at the frame end), counter increments.
- ser_last <= 1 on the edge that registers the 8th bit.
- After the 8th select position:
  - state goes to GAP if IDLE_GAP>0, otherwise to IDLE;
  - mux_sel returns to the start index.

GAP:
- ser_valid = 0.
- Stays IDLE_GAP cycles, then goes to IDLE.

Latency:
- Handshake edge at cycle T.
- mux_sel presents positions during cycles T+1..T+8.
- ser_valid is high during cycles T+2..T+9; ser_last is high only in cycle T+9.

Throughput and timing rules:
- Minimum spacing between accepted words is 9+IDLE_GAP cycles.
- in_valid held high continuously is accepted again at the first IDLE cycle.
- ser_valid, ser_last and ser_out are registered; they are 0/0/0 on every cycle with no bit.
- No downstream backpressure: the consumer must accept one bit per cycle while ser_valid is high.

Reset mid-frame:
- Asserting rst_n low immediately returns every output to its reset value.
- The partial frame is discarded and no ser_last is issued.
- After deassertion the block is in IDLE and accepts a new word on the next handshake.

Optional Feature:
- Macro: MUX8_SER_PARITY_EN.
- Defined:
  - After the 8th data bit the FSM enters PAR for one cycle and emits the even-parity bit (XOR of mux_a) with ser_valid=1.
  - ser_last moves from the 8th data bit to the parity bit.
  - Frame length is 9 bits; minimum word spacing is 10+IDLE_GAP cycles.
- Undefined: PAR state and parity logic are absent; frames are 8 bits.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → all outputs at reset values, in_ready=1, no handshake taken; after release, one word is accepted on the first edge.
- MSB_FIRST=0, single word 0xA5 → mux_sel 0..7 on T+1..T+8; ser_out 1,0,1,0,0,1,0,1 on T+2..T+9; ser_last only at T+9; busy high T+1..T+8.
- MSB_FIRST=1, word 0x81, then 0x3C with in_valid held high → bit streams 1,0,0,0,0,0,0,1 then 0,0,1,1,1,1,0,0. Second handshake at the first IDLE cycle; in_data changes during SHIFT are ignored.
- IDLE_GAP=2, two back-to-back words → exactly 2 GAP cycles plus 1 IDLE cycle between ser_last of word 1 and the first ser_valid of word 2.
- Mid-frame reset after 4 bits of 0xFF → outputs drop to 0 asynchronously with no ser_last; next word 0x01 serializes fully and correctly.
- MUX8_SER_PARITY_EN defined, word 0x07 → 9 valid bits 1,1,1,0,0,0,0,0 then parity 1; ser_last on the 9th bit; word 0x03 gives parity 0.
